rgb_clip_pack_scheduler: RTL
============================

// Module: rgb_clip_pack_scheduler
// PURPOSE
//  Sequences one shared clipper instance over the six 16-bit colour-conversion results of a
//  pixel pair (R0,G0,B0,R1,G1,B1). Packs the clipped bytes into three 16-bit SRAM words and
//  issues them as sequential writes into the RGB segment. Sits between the CSC multiplier
//  accumulators and the SRAM write port. Counts pairs per frame and flags frame completion.
// PARAMETERS
//  ADDR_W     18       SRAM address width
//  RGB_BASE   146944   first SRAM word address of the RGB segment
//  NUM_PAIRS  38400    pixel pairs per frame (320x240/2); frame = 3*NUM_PAIRS words
// PORTS
//  Clock            in   1       system clock; all logic on rising edge
//  Reset            in   1       synchronous, active-high reset
//  start            in   1       1-cycle pulse: begin frame at RGB_BASE (ignored unless IDLE)
//  in_valid         in   1       pixel-pair values valid
//  in_ready         out  1       block can accept a pair this cycle
//  R0,G0,B0,R1,G1,B1 in  16 each unclipped conversion results (already >>16)
//  SRAM_address     out  ADDR_W  write word address
//  SRAM_write_data  out  16      packed bytes, first byte in [15:8]
//  SRAM_we_n        out  1       active-low write enable
//  busy             out  1       high from accepted start until done
//  done             out  1       1-cycle pulse after last frame word is written
// BEHAVIOUR
//  Reset: state IDLE; phase=0, word_cnt=0, pair_cnt=0; in_ready=0, SRAM_we_n=1,
//   SRAM_address=RGB_BASE, SRAM_write_data=0, busy=0, done=0. Applies mid-frame too:
//   any in-flight pair is discarded and no further writes are issued.
//  Clip function (shared clipper, its Resetn tied to ~Reset): hi=v[15:8], lo=v[7:0];
//   hi==8'hFF && lo>=8'hF8 -> 8'h00; hi==8'h01 && lo<=8'd8 -> 8'hFF; else -> lo.
//   Exactly one clip per cycle; no other clip instance is permitted.
//  States: IDLE -> (start) WAIT_IN -> (in_valid&&in_ready) CLIP -> WAIT_IN or DONE -> IDLE.
//  IDLE: in_ready=0; in_valid ignored. start: word_cnt=0, pair_cnt=0, busy<=1, go to WAIT_IN.
//  WAIT_IN: in_ready=1 (combinational from state). Handshake latches all six values, phase=0.
//  CLIP: phase 0..5 selects R0,G0,B0,R1,G1,B1 into the clipper, one per cycle.
//   Even phase: clipped byte -> hold register.
//   Odd phase: at that edge, register SRAM_write_data<={hold,clipped},
//   SRAM_address<=RGB_BASE+word_cnt, SRAM_we_n<=0, then word_cnt++.
//   SRAM_we_n returns to 1 on every cycle that is not an odd-phase write.
//  Word order per pair: {R0,G0}, {B0,R1}, {G1,B1} at consecutive addresses.
//  Latency: handshake at edge E -> writes visible after E+2, E+4, E+6. Throughput 1 pair / 7 cycles.
//  End of phase 5: pair_cnt++. If pair_cnt was NUM_PAIRS-1, go to DONE, else WAIT_IN.
//  DONE (1 cycle): done=1, busy<=0, then IDLE. Last write and done are on consecutive cycles.
//  No wrap: word_cnt max 3*NUM_PAIRS-1. Address is computed at full ADDR_W width.
//  start during WAIT_IN/CLIP/DONE: ignored, no effect on counters.
//  in_valid low in WAIT_IN: hold state indefinitely; outputs stable, SRAM_we_n=1.
//  Values are sampled only at handshake; input changes during CLIP have no effect.
// TESTING
//  Clip bounds: NUM_PAIRS=1, R0..B1 = FFF8,FFF7,0108,0109,0042,00FF
//   -> words 0x00F7 @146944, 0xFF09 @146945, 0x42FF @146946; done 1 cycle later.
//  Timing: handshake at edge E -> we_n=0 exactly in cycles E+2, E+4, E+6, else 1; in_ready=0
//   during CLIP.
//  Backpressure/frame: NUM_PAIRS=2, in_valid idle 10 cycles between pairs
//   -> 6 writes at 146944..146949, no writes while waiting, done once, busy falls with done.
//  Reset mid-op: Reset at phase 3 of pair 0 -> no further writes, in_ready=0, address=RGB_BASE.
//   New start rewrites from 146944.
//  Ignored inputs: start pulse while in CLIP -> counters unchanged.
//   in_valid=1 while IDLE -> no capture, no write.

Source files
------------

// File: rtl/rgb_clip_pack_scheduler.sv
// Clips the six conversion results of a pixel pair through one shared clipper and
// writes them as three packed 16-bit words into the RGB segment of SRAM.
module rgb_clip_pack_scheduler #(
  parameter int ADDR_W    = 18,
  parameter int RGB_BASE  = 146944,
  parameter int NUM_PAIRS = 38400
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       R0,
  input  logic [15:0]       G0,
  input  logic [15:0]       B0,
  input  logic [15:0]       R1,
  input  logic [15:0]       G1,
  input  logic [15:0]       B1,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              busy,
  output logic              done
);

  localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_CLIP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            phase_q, phase_d;
  logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
  logic [PAIR_W-1:0]     pair_cnt_q, pair_cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  we_n_q, we_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [5:0][15:0]      vals_q, vals_d;
  logic [7:0]            hold_q, hold_d;
  logic [15:0]           clip_in;
  logic [7:0]            clip_out;

  // Values within 8 of the byte range are treated as small under/overshoot.
  function automatic logic [7:0] clip8(input logic [15:0] v);
    if (v[15:8] == 8'hFF && v[7:0] >= 8'hF8) begin
      return 8'h00;
    end else if (v[15:8] == 8'h01 && v[7:0] <= 8'd8) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

  always_comb begin
    clip_in = vals_q[5];
    case (phase_q)
      3'd0:    clip_in = vals_q[0];
      3'd1:    clip_in = vals_q[1];
      3'd2:    clip_in = vals_q[2];
      3'd3:    clip_in = vals_q[3];
      3'd4:    clip_in = vals_q[4];
      default: clip_in = vals_q[5];
    endcase
  end

  assign clip_out = clip8(clip_in);
  assign in_ready = (state_q == S_WAIT_IN);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    word_cnt_d = word_cnt_q;
    pair_cnt_d = pair_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_n_d     = 1'b1;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vals_d     = vals_q;
    hold_d     = hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_cnt_d = '0;
          pair_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          vals_d  = {B1, G1, R1, B0, G0, R0};
          phase_d = 3'd0;
          state_d = S_CLIP;
        end
      end
      S_CLIP: begin
        phase_d = phase_q + 3'd1;
        if (!phase_q[0]) begin
          hold_d = clip_out;
        end else begin
          data_d     = {hold_q, clip_out};
          addr_d     = ADDR_W'(RGB_BASE) + word_cnt_q;
          we_n_d     = 1'b0;
          word_cnt_d = word_cnt_q + ADDR_W'(1);
        end
        if (phase_q == 3'd5) begin
          phase_d    = 3'd0;
          pair_cnt_d = pair_cnt_q + PAIR_W'(1);
          state_d    = (pair_cnt_q == PAIR_W'(NUM_PAIRS - 1)) ? S_DONE : S_WAIT_IN;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      word_cnt_q <= '0;
      pair_cnt_q <= '0;
      addr_q     <= ADDR_W'(RGB_BASE);
      data_q     <= 16'h0000;
      we_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      word_cnt_q <= word_cnt_d;
      pair_cnt_q <= pair_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_n_q     <= we_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Captured pair and even-phase byte
  always_ff @(posedge Clock) begin
    vals_q <= vals_d;
    hold_q <= hold_d;
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = data_q;
  assign SRAM_we_n       = we_n_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
